// File: rtl/multi_circle_pkg.sv
// Shared types for the multi-circle midpoint generator: FSM states, octant index, octant sign/swap table.
package multi_circle_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        EMIT = 3'd2,
        STEP = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef logic [2:0] oct_t;

    typedef struct packed {
        logic swap;
        logic neg_x;
        logic neg_y;
    } oct_ctl_t;

    localparam oct_t OCT_LAST = 3'd7;

    // {swap, neg_x, neg_y}: (+x,+y)(+y,+x)(-y,+x)(-x,+y)(-x,-y)(-y,-x)(+y,-x)(+x,-y)
    localparam logic [2:0] OCT_TABLE [8] = '{
        3'b000, 3'b100, 3'b110, 3'b010, 3'b011, 3'b111, 3'b101, 3'b001
    };

endpackage

// File: rtl/circle_octant_mux.sv
// Maps (x, y) offset and octant index onto an absolute point about (cx, cy); flags points off the clip window.
// Purely combinational; clip flag is only generated when MULTI_CIRCLE_CLIP_EN is defined.
module circle_octant_mux
    import multi_circle_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CLIP_BITS = 8
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] cx,
    input  logic signed [WIDTH-1:0] cy,
    input  oct_t                    oct,
    output logic signed [WIDTH-1:0] px,
    output logic signed [WIDTH-1:0] py,
    output logic                    clip
);

    oct_ctl_t                ctl;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;

    always_comb begin
        ctl = oct_ctl_t'(OCT_TABLE[oct]);
        a   = ctl.swap ? y : x;
        b   = ctl.swap ? x : y;
        px  = ctl.neg_x ? (cx - a) : (cx + a);
        py  = ctl.neg_y ? (cy - b) : (cy + b);
    end

`ifdef MULTI_CIRCLE_CLIP_EN
    // Logical shift: any bit at or above CLIP_BITS (including sign) means outside [0, 2**CLIP_BITS-1].
    assign clip = ((px >> CLIP_BITS) != '0) || ((py >> CLIP_BITS) != '0);
`else
    assign clip = 1'b0;
`endif

endmodule

// File: rtl/multi_circle.sv
// Streaming midpoint generator for CIRCLES equal circles spaced by radius; one point per _valid/_ready transfer.
// Latency: first _valid two edges after _start; outputs held while _ready=0. Optional MULTI_CIRCLE_CLIP_EN.
module multi_circle
    import multi_circle_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CIRCLES   = 3,
    parameter int CLIP_BITS = 8
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic                    _ready,
    input  logic signed [WIDTH-1:0] centre_x,
    input  logic signed [WIDTH-1:0] centre_y,
    input  logic signed [WIDTH-1:0] radius,
    output logic                    _valid,
    output logic                    _done,
    output logic [WIDTH-1:0]        _0,
    output logic [WIDTH-1:0]        _1
);

    localparam int KW = (CIRCLES > 1) ? $clog2(CIRCLES) : 1;
    localparam int EW = WIDTH + 2;
    localparam logic [KW-1:0]        K_LAST = KW'(CIRCLES - 1);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);

    state_t                  state, n_state;
    logic signed [WIDTH-1:0] x, y, cx, cy, r;
    logic signed [WIDTH-1:0] n_x, n_y, n_cx;
    logic signed [EW-1:0]    err, n_err;
    oct_t                    oct, n_oct;
    logic [KW-1:0]           k, n_k;
    logic                    adv;

    logic signed [WIDTH-1:0] sy, sx, step_x;
    logic signed [EW-1:0]    sy_e, sx_e, r_e, step_err;

    logic signed [WIDTH-1:0] px, py;
    logic                    clip;

    always_comb begin
        n_state = state;
        n_x     = x;
        n_y     = y;
        n_err   = err;
        n_oct   = oct;
        n_k     = k;
        n_cx    = cx;
        adv     = 1'b0;

        sy   = y + 1'b1;
        sx   = x - 1'b1;
        sy_e = sy;
        sx_e = sx;
        r_e  = r;
        // Midpoint step using the already-incremented y (and decremented x when err>=0).
        if (err[EW-1]) begin
            step_x   = x;
            step_err = err + (sy_e <<< 1) + ONE_E;
        end else begin
            step_x   = sx;
            step_err = err + ((sy_e - sx_e) <<< 1) + ONE_E;
        end

        case (state)
            IDLE, DONE: begin
                if (_start) begin
                    n_state = INIT;
                    n_k     = '0;
                    n_cx    = centre_x;
                end
            end
            INIT: begin
                if (r < 0) begin
                    adv = 1'b1;
                end else begin
                    n_x     = r;
                    n_y     = '0;
                    n_err   = ONE_E - r_e;
                    n_oct   = '0;
                    n_state = EMIT;
                end
            end
            EMIT: begin
                // A suppressed (clipped) point leaves _valid low, so it advances without waiting.
                if (!_valid || _ready) begin
                    if (oct == OCT_LAST) n_state = STEP;
                    else                 n_oct   = oct + 3'd1;
                end
            end
            STEP: begin
                n_y   = sy;
                n_x   = step_x;
                n_err = step_err;
                if (step_x >= sy) begin
                    n_oct   = '0;
                    n_state = EMIT;
                end else begin
                    adv = 1'b1;
                end
            end
            default: n_state = IDLE;
        endcase

        if (adv) begin
            if (k == K_LAST) begin
                n_state = DONE;
            end else begin
                n_k     = k + 1'b1;
                n_cx    = cx + r;
                n_state = INIT;
            end
        end
    end

    // Fed with next-state values so the registered point lines up with the cycle it is presented.
    circle_octant_mux #(
        .WIDTH     (WIDTH),
        .CLIP_BITS (CLIP_BITS)
    ) u_mux (
        .x    (n_x),
        .y    (n_y),
        .cx   (n_cx),
        .cy   (cy),
        .oct  (n_oct),
        .px   (px),
        .py   (py),
        .clip (clip)
    );

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            cx     <= '0;
            cy     <= '0;
            r      <= '0;
            err    <= '0;
            oct    <= '0;
            k      <= '0;
            _valid <= 1'b0;
            _done  <= 1'b0;
            _0     <= '0;
            _1     <= '0;
        end else begin
            state <= n_state;
            x     <= n_x;
            y     <= n_y;
            cx    <= n_cx;
            err   <= n_err;
            oct   <= n_oct;
            k     <= n_k;
            if ((state == IDLE || state == DONE) && _start) begin
                cy <= centre_y;
                r  <= radius;
            end
            _done  <= (n_state == DONE);
            _valid <= (n_state == EMIT) && !clip;
            if (n_state == EMIT) begin
                _0 <= px;
                _1 <= py;
            end
        end
    end

endmodule

// File: tb/tb_multi_circle.sv
// Randomised scoreboard bench for multi_circle against a behavioural midpoint-circle model.
module tb_multi_circle;

    localparam int W  = 32;
    localparam int NC = 3;
    localparam int CB = 8;

    typedef struct {
        int x;
        int y;
    } pt_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                ready = 1'b1;
    logic signed [W-1:0] cx_i = '0;
    logic signed [W-1:0] cy_i = '0;
    logic signed [W-1:0] r_i  = '0;
    logic                valid;
    logic                done;
    logic [W-1:0]        p0;
    logic [W-1:0]        p1;

    int  checks = 0;
    int  errors = 0;
    int  xfers  = 0;
    int  ready_mode = 0;
    pt_t exp_q[$];

    always #5 clk = ~clk;

    multi_circle #(.WIDTH(W), .CIRCLES(NC), .CLIP_BITS(CB)) dut (
        ._clock   (clk),
        ._reset   (rst_n),
        ._start   (start),
        ._ready   (ready),
        .centre_x (cx_i),
        .centre_y (cy_i),
        .radius   (r_i),
        ._valid   (valid),
        ._done    (done),
        ._0       (p0),
        ._1       (p1)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic bit in_win(input int v);
        return (v >= 0) && (v <= (1 << CB) - 1);
    endfunction

    // Reference: midpoint circle in plain integers, eight symmetric points per iteration.
    task automatic model_push(input int cx, input int cy, input int r);
        int  c, x, y, err;
        int  dx[8];
        int  dy[8];
        pt_t p;
        c = cx;
        for (int kk = 0; kk < NC; kk++) begin
            if (r >= 0) begin
                x = r; y = 0; err = 1 - r;
                while (x >= y) begin
                    dx = '{x, y, -y, -x, -x, -y, y, x};
                    dy = '{y, x, x, y, -y, -x, -x, -y};
                    for (int o = 0; o < 8; o++) begin
                        p.x = c + dx[o];
                        p.y = cy + dy[o];
`ifdef MULTI_CIRCLE_CLIP_EN
                        if (in_win(p.x) && in_win(p.y)) exp_q.push_back(p);
`else
                        exp_q.push_back(p);
`endif
                    end
                    y++;
                    if (err < 0) err += 2 * y + 1;
                    else begin
                        x--;
                        err += 2 * (y - x) + 1;
                    end
                end
            end
            c += r;
        end
    endtask

    // Ready driver, changes well after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: a transfer happens at the next posedge when valid&&ready are seen here.
    logic         stall_prev = 1'b0;
    logic [W-1:0] hold_x, hold_y;
    always @(negedge clk) begin
        pt_t p;
        if (rst_n) begin
            if (stall_prev) begin
                check("hold_valid", valid, 1);
                check("hold_x", p0, hold_x);
                check("hold_y", p1, hold_y);
            end
            if (valid && ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_point: got (%0d,%0d) required none", $signed(p0), $signed(p1));
                end else begin
                    p = exp_q.pop_front();
                    check("pt_x", $signed(p0), p.x);
                    check("pt_y", $signed(p1), p.y);
                end
            end
            stall_prev = valid && !ready;
            hold_x     = p0;
            hold_y     = p1;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic issue(input int cx, input int cy, input int r);
        @(posedge clk);
        #2;
        cx_i = cx; cy_i = cy; r_i = r;
        start = 1'b1;
        model_push(cx, cy, r);
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
        check("queue_empty", exp_q.size(), 0);
        check("valid_in_done", valid, 0);
        exp_q.delete();
    endtask

    initial begin
        #12;
        check("rst_valid", valid, 0);
        check("rst_done", done, 0);
        check("rst_x", p0, 0);
        check("rst_y", p1, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Zero radius, unit radius, and the reference three-circle job.
        issue(5, 5, 0);   wait_done();
        issue(0, 0, 1);   wait_done();
        xfers = 0;
        issue(50, 50, 8); wait_done();
        check("count_r8", xfers, 144);
        issue(-3, 7, -1); wait_done();

        // Backpressure
        ready_mode = 1;
        issue(0, 0, 1);   wait_done();
        for (int j = 0; j < 6; j++) begin
            issue(int'($urandom_range(0, 200)), int'($urandom_range(0, 200)),
                  int'($urandom_range(0, 22)) - 2);
            wait_done();
        end

        // Start pulse while busy must not disturb the job.
        issue(50, 50, 8);
        repeat (20) @(posedge clk);
        #2;
        cx_i = 7; cy_i = 9; r_i = 3; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done();

        // Start from DONE: first valid two edges later.
        ready_mode = 0;
        @(posedge clk);
        #2;
        cx_i = 100; cy_i = 100; r_i = 3; start = 1'b1;
        model_push(100, 100, 3);
        @(posedge clk);
        #1;
        check("lat_e0_valid", valid, 0);
        check("lat_e0_done", done, 0);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        check("lat_e1_valid", valid, 1);
        wait_done();

        // Asynchronous reset mid-EMIT.
        issue(50, 50, 8);
        begin
            int n = 0;
            while (!valid && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("reach_emit", valid, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", valid, 0);
        check("arst_done", done, 0);
        check("arst_x", p0, 0);
        check("arst_y", p1, 0);
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_valid", valid, 0);
        issue(20, 20, 2); wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
